// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared FSM encoding and default sizes for the serial pattern checker
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/serial_pattern_checker_sat_counter.sv
// rtl/serial_pattern_checker_sat_counter.sv - saturating incrementer with synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/serial_pattern_checker.sv
// rtl/serial_pattern_checker.sv - compares a serial bit stream against a latched WIDTH-bit pattern
module serial_pattern_checker
  import checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         expected,
  input  logic                     sample_valid,
  input  logic                     sample_bit,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         bit_errors,
  output logic [$clog2(WIDTH)-1:0] first_err_idx,
  output logic [WIDTH-1:0]         captured
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] captured_q, captured_d;
  logic [IDX_W-1:0] first_err_q, first_err_d;
  logic             pass_q, pass_d;

  logic             take;
  logic             mism;
  logic             err_clr;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] err_next;

  // Pattern is consumed MSB first, so sample n is checked against bit WIDTH-1-n.
  assign bit_idx = LAST_IDX - cnt_q;
  assign take    = (state_q == ST_CAPTURE) && sample_valid;
  assign mism    = take && (sample_bit != exp_q[bit_idx]);

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (err_clr),
    .inc        (mism),
    .count      (err_count),
    .count_next (err_next)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    captured_d  = captured_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    err_clr     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d     = ST_CAPTURE;
          exp_d       = expected;
          cnt_d       = '0;
          captured_d  = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          err_clr     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (take) begin
          captured_d = {captured_q[WIDTH-2:0], sample_bit};
          cnt_d      = cnt_q + 1'b1;
          if (mism && (err_count == '0)) begin
            first_err_d = cnt_q;
          end
          // The final sample's mismatch must count, so use the counter's next value.
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            pass_d  = (err_next == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      cnt_q       <= '0;
      captured_q  <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign busy          = (state_q == ST_CAPTURE);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign bit_errors    = err_count;
  assign first_err_idx = first_err_q;
  assign captured      = captured_q;

endmodule

// File: doc/serial_pattern_checker.md
Name: serial_pattern_checker

Overview:
Receive-side counterpart to the serial stimulus drivers used around the flip-flop blocks. It samples a single-bit serial stream, such as a flip-flop Q output, on qualified clock edges. It compares a WIDTH-bit window against a programmed expected pattern, MSB first, and reports pass/fail, an error count and the position of the first mismatch. It sits next to a DUT in self-checking benches and on-chip loopback tests.

Parameters:
WIDTH, 8, pattern length in bits (>= 2)
CNT_W, 8, width of the saturating bit-error counter
IDX_W, $clog2(WIDTH), width of sample index and first-error index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; arms a new check run
expected  input  WIDTH  reference pattern; latched on accepted start
sample_valid  input  1  qualifies sample_bit in the current cycle
sample_bit  input  1  serial data bit under test
busy  output  1  high while in CAPTURE
done  output  1  one-cycle pulse when a run completes
pass  output  1  run result; 1 = zero mismatches; held until next accepted start
bit_errors  output  CNT_W  mismatch count of last/current run, saturating
first_err_idx  output  IDX_W  received-order index (0 = first sample) of first mismatch
captured  output  WIDTH  shift register of received bits; first sample ends in MSB after a full run

Behaviour:
- Reset: synchronous on reset=1 at a rising clk edge. Overrides every other input and aborts any run in progress. All outputs go to 0: busy, done, pass, bit_errors, first_err_idx, captured. FSM goes to IDLE, and the internal expected latch and sample counter are cleared.
- FSM states are IDLE, CAPTURE and DONE. Encoding constants live in the package.
- IDLE:
  - start=1 accepts a run: latch expected, clear bit_errors, first_err_idx, captured, pass and the sample counter.
  - Next state is CAPTURE.
- CAPTURE:
  - busy=1. start is ignored.
  - Each cycle with sample_valid=1:
    - Compare sample_bit with exp_latch[WIDTH-1-cnt].
    - captured <= {captured[WIDTH-2:0], sample_bit}.
    - cnt increments.
  - sample_valid=0 causes no state change; gaps of any length are allowed.
- Mismatch handling:
  - bit_errors increments and saturates at 2^CNT_W-1.
  - On the first mismatch only (bit_errors==0 before the update), first_err_idx <= cnt.
- Completion: when the WIDTH-th valid sample is taken (cnt==WIDTH-1 with sample_valid), next state is DONE.
- DONE:
  - Exactly one cycle: done=1, busy=0.
  - pass=1 iff final bit_errors==0. The last sample's mismatch is included, so pass is registered from the next-value count.
- After DONE:
  - start=1 during DONE accepts a new run and goes to CAPTURE. Otherwise next state is IDLE.
  - pass, bit_errors, first_err_idx and captured hold until the next accepted start.
- Latency: done asserts on the cycle after the edge that sampled the final bit. This is WIDTH cycles after start acceptance with continuous sample_valid.
- Changing expected during CAPTURE has no effect; only the latched copy is used.
- start and sample_valid in the same IDLE cycle: start is accepted, and that sample is not taken.
- With no mismatch, first_err_idx stays 0. Consumers qualify it with bit_errors!=0.

Decomposition:
- Shared package (checker_pkg):
  - FSM state typedef/localparams: IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2.
  - Default WIDTH/CNT_W constants.
- One natural sub-module, sat_counter: a CNT_W-bit saturating incrementer with synchronous clear, used for bit_errors.
- Shift register, compare and FSM stay in the top.

Test Plan:
1. WIDTH=8, expected=8'b1010_0110, start, then drive 1,0,1,0,0,1,1,0 with continuous sample_valid -> done pulses 8 cycles after start; pass=1, bit_errors=0, captured=8'hA6.
2. Same expected, stream 1,1,1,0,0,1,0,0 -> mismatches at indices 1 and 6; done with pass=0, bit_errors=2, first_err_idx=1, captured=8'hE4.
3. Same as 1 with sample_valid low for 3 cycles after each of samples 2 and 5 -> done 14 cycles after start; results identical to 1, busy high throughout.
4. Reset asserted for 1 cycle after 4 samples -> next cycle all outputs 0, FSM IDLE. A new start plus 8 good samples gives pass=1.
5. start pulses during CAPTURE -> ignored, run completes normally. start during the DONE cycle -> busy=1 the next cycle and prior results clear.
6. CNT_W=2, expected=8'h00, stream of eight 1s -> bit_errors saturates at 3, first_err_idx=0, pass=0.
